// File: rtl/cpu_pkg.sv
// Shared constants for the register FIFO and its pointer/flag controller.
package cpu_pkg;

    localparam int WORD_WIDTH = 64;
    localparam int FIFO_DEPTH = 4;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int occ_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : cpu_pkg

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for a power-of-two register FIFO.
// Flush beats any push/pop in the same cycle; storage writes are only
// enabled through push_o, so a flushed or rejected write never touches memory.
module fifo_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = occ_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n_i,
    input  logic          wr_valid_i,
    input  logic          rd_ready_i,
    input  logic          flush_i,
    output logic          wr_ready_o,
    output logic          rd_valid_o,
    output logic          push_o,
    output logic [PW-1:0] wr_ptr_o,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop;

    // Handshake status is derived only from registered occupancy, so a full
    // FIFO never passes a write through even when a pop happens that cycle.
    assign wr_ready_o = (count_q != CW'(DEPTH));
    assign rd_valid_o = (count_q != '0);
    assign push_o     = wr_valid_i & wr_ready_o & ~flush_i;
    assign pop        = rd_valid_o & rd_ready_i & ~flush_i;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Pointer width equals log2(DEPTH), so natural wrap is mod DEPTH.
            if (push_o) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_o, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_valid_i && !wr_ready_o) begin
                overflow_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_ptr_o   = wr_ptr_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule : fifo_ctrl

// File: rtl/reg_fifo_64.sv
// Show-ahead register FIFO: storage array and read mux; bookkeeping lives in
// fifo_ctrl. Storage is deliberately not reset; it is invisible while empty.
module reg_fifo_64
    import cpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = WORD_WIDTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n_i    (reset),
        .wr_valid_i (wr_valid),
        .rd_ready_i (rd_ready),
        .flush_i    (flush),
        .wr_ready_o (wr_ready),
        .rd_valid_o (rd_valid),
        .push_o     (push),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count),
        .overflow_o (overflow)
    );

    // Storage only changes on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    // Head of queue is presented directly; zeros when nothing is held.
    assign rd_data = rd_valid ? mem_q[rd_ptr] : '0;

endmodule : reg_fifo_64

// File: tb/tb_reg_fifo_64.sv
// Directed bench for reg_fifo_64 with a scoreboard queue and a decoupled
// monitor that checks every value popped by the consumer.
module tb_reg_fifo_64;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        rd_ready;
    logic        flush;
    logic [2:0]  count;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          mcount = 0;
    logic        movf = 1'b0;

    reg_fifo_64 dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .flush    (flush),
        .count    (count),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change just after posedge, so at negedge the handshake
    // seen here is the one the next edge will act on.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            chk("mon_rd_valid", {63'd0, rd_valid}, {63'd0, exp_q.size() != 0});
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_pop", rd_data, 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_rd_data", rd_data, e);
                end
            end
        end
    end

    // One clock of stimulus; model updated after the edge.
    task automatic step(input logic wv, input logic [63:0] wd, input logic rr, input logic fl);
        logic push_ok;
        logic pop_ok;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        push_ok  = wv && (mcount < DEPTH) && !fl;
        pop_ok   = rr && (mcount > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            mcount = 0;
            movf   = 1'b0;
        end else begin
            if (wv && mcount == DEPTH) movf = 1'b1;
            if (push_ok) exp_q.push_back(wd);
            mcount = mcount + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        #1;
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Three pushes, no reads
        step(1'b1, 64'h1B, 1'b0, 1'b0);
        chk("first_push_latency", rd_data, 64'h1B);
        step(1'b1, 64'h863, 1'b0, 1'b0);
        step(1'b1, 64'h1E, 1'b0, 1'b0);
        chk("fill3_count", {61'd0, count}, 64'd3);
        chk("fill3_rd_data", rd_data, 64'h1B);
        chk("fill3_wr_ready", {63'd0, wr_ready}, 64'd1);

        // Fill to full, then hammer with a rejected write
        step(1'b1, 64'h44, 1'b0, 1'b0);
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_wr_ready", {63'd0, wr_ready}, 64'd0);
        chk("full_ovf_before", {63'd0, overflow}, 64'd0);
        step(1'b1, 64'hDEAD, 1'b0, 1'b0);
        chk("ovf_set", {63'd0, overflow}, {63'd0, movf});
        chk("ovf_count", {61'd0, count}, 64'd4);
        step(1'b1, 64'hDEAD, 1'b0, 1'b0);
        // Full with pop and push offered: only the pop happens
        step(1'b1, 64'hDEAD, 1'b1, 1'b0);
        chk("full_pushpop_count", {61'd0, count}, 64'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("drain_count", {61'd0, count}, 64'd0);
        chk("ovf_sticky", {63'd0, overflow}, 64'd1);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("flush_ovf_clear", {63'd0, overflow}, 64'd0);

        // Empty: push and pop offered together, only push happens
        step(1'b1, 64'h5, 1'b1, 1'b0);
        chk("empty_pushpop_count", {61'd0, count}, 64'd1);
        chk("empty_pushpop_data", rd_data, 64'h5);

        // Steady push+pop at count 2, crossing the pointer wrap
        step(1'b1, 64'h100, 1'b0, 1'b0);
        chk("steady_pre_count", {61'd0, count}, 64'd2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 64'h200 + 64'(i), 1'b1, 1'b0);
            chk("steady_count", {61'd0, count}, 64'(mcount));
            chk("steady_wr_ready", {63'd0, wr_ready}, 64'd1);
        end
        chk("steady_head", rd_data, 64'h208);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("steady_drained", {61'd0, count}, 64'd0);

        // Flush at count 3 with overflow set, push and pop also requested
        for (int i = 0; i < 4; i++) step(1'b1, 64'h30 + 64'(i), 1'b0, 1'b0);
        step(1'b1, 64'hBAD, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("preflush_count", {61'd0, count}, 64'd3);
        chk("preflush_ovf", {63'd0, overflow}, 64'd1);
        step(1'b1, 64'h99, 1'b1, 1'b1);
        chk("flush_count", {61'd0, count}, 64'd0);
        chk("flush_ovf", {63'd0, overflow}, 64'd0);
        chk("flush_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("flush_rd_data", rd_data, 64'd0);

        // Asynchronous reset in mid-cycle with two entries pending
        step(1'b1, 64'hA1, 1'b0, 1'b0);
        step(1'b1, 64'hA2, 1'b0, 1'b0);
        wr_valid = 1'b0;
        chk("prereset_count", {61'd0, count}, 64'd2);
        #2 reset = 1'b0;
        exp_q.delete();
        mcount = 0;
        movf   = 1'b0;
        #1;
        chk("async_rst_count", {61'd0, count}, 64'd0);
        chk("async_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("async_rst_rd_data", rd_data, 64'd0);
        chk("async_rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        #3 reset = 1'b1;
        step(1'b1, 64'h7, 1'b0, 1'b0);
        chk("postrst_rd_data", rd_data, 64'h7);
        chk("postrst_count", {61'd0, count}, 64'd1);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("final_count", {61'd0, count}, 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_fifo_64

// File: doc/reg_fifo_64.md
REG_FIFO_64 -- requirements
Module: reg_fifo_64

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 64-bit entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 64, data bits per entry.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid, input, 1, producer offers wr_data this cycle.
REQ-006 SHALL have port wr_data, input, WIDTH, data to enqueue.
REQ-007 SHALL have port wr_ready, output, 1, FIFO can accept a write this cycle.
REQ-008 SHALL have port rd_valid, output, 1, rd_data holds the oldest entry.
REQ-009 SHALL have port rd_data, output, WIDTH, oldest entry (show-ahead).
REQ-010 SHALL have port rd_ready, input, 1, consumer takes rd_data this cycle.
REQ-011 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-013 SHALL have port overflow, output, 1, sticky flag: write attempted while full.

Function
REQ-014 SHALL define push = wr_valid && wr_ready, pop = rd_valid && rd_ready.
REQ-015 SHALL drive wr_ready = (count != DEPTH) combinationally from registered state; no pass-through when full.
REQ-016 SHALL drive rd_valid = (count != 0); rd_data = entry at read pointer when rd_valid, else all zeros.
REQ-017 SHALL on push write wr_data at write pointer and advance it by 1 mod DEPTH at the same edge.
REQ-018 SHALL on pop advance read pointer by 1 mod DEPTH; new head visible on rd_data the cycle after the edge.
REQ-019 SHALL update count: +1 on push only, -1 on pop only, unchanged on push and pop together or neither.
REQ-020 SHALL have latency one cycle: data pushed at edge N is on rd_data with rd_valid=1 after edge N when FIFO was empty.
REQ-021 SHALL accept simultaneous push and pop when 0<count<DEPTH; when empty only push occurs; when full only pop occurs and wr_ready stays 0 that cycle.
REQ-022 SHALL preserve strict FIFO ordering across pointer wrap-around.
REQ-023 SHALL set overflow at the edge where wr_valid=1 and wr_ready=0; it holds until flush or reset; rejected data is discarded.
REQ-024 SHALL on flush=1 at an edge set both pointers and count to 0 and clear overflow; push and pop that cycle are ignored.
REQ-025 SHALL never change storage contents except at a push.

Reset
REQ-026 SHALL on reset=0 asynchronously force read/write pointers=0, count=0, overflow=0, so rd_valid=0, rd_data=0, wr_ready=1.
REQ-027 SHALL not reset storage array; contents are unobservable while count=0.
REQ-028 SHALL, on reset asserted mid-operation, discard all pending entries; first post-reset push behaves as on an empty FIFO.

Structure
REQ-029 SHALL place WORD_WIDTH=64 and default FIFO depth constant in shared package cpu_pkg.
REQ-030 SHALL split pointer/count/flag logic into sub-module fifo_ctrl; storage and output mux stay in reg_fifo_64.

Verification
REQ-031 Reset then push 0x1B, 0x863, 0x1E on consecutive cycles, rd_ready=0 -> count=3, rd_data=0x1B, wr_ready=1.
REQ-032 Fill 4 entries, hold wr_valid=1 with 0xDEAD -> wr_ready=0, overflow=1 next edge, pops return only the 4 original values in order.
REQ-033 Push+pop every cycle for 10 cycles at count=2 -> count stays 2, outputs match input order delayed by 2 entries across pointer wrap.
REQ-034 Empty FIFO, wr_valid=1 and rd_ready=1 with 0x5 -> count=1 after edge, rd_data=0x5, no pop occurred.
REQ-035 count=3, overflow=1, assert flush with push and pop -> count=0, overflow=0, rd_valid=0, rd_data=0.
REQ-036 count=2, drive reset=0 between clock edges -> count=0, rd_valid=0 immediately; after release, push 0x7 -> rd_data=0x7, count=1.
